mpu_load_ctrl: RTL and testbench
================================

MPU_LOAD_CTRL -- requirements
Module: mpu_load_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning matrix dimension (N x N int8 operands).
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum COMPUTE cycles before an error is flagged.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle request to load A, load B, then compute.
REQ-007 a_base  input  16  DRAM byte address of A[0][0], row-major.
REQ-008 b_base  input  16  DRAM byte address of B[0][0], row-major.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse on successful completion.
REQ-011 err  output  1  one-cycle pulse on COMPUTE timeout.
REQ-012 dram_addr  output  16  DRAM read address (read-only use, wen tied 0).
REQ-013 dram_dout  input  8  DRAM read data, valid exactly 1 cycle after dram_addr.
REQ-014 ld_en  output  1  MPU operand write strobe.
REQ-015 ld_sel  output  1  0 = A, 1 = B.
REQ-016 ld_row, ld_col  output  3 each  element index of the operand being written.
REQ-017 ld_data  output  8  element value (equals dram_dout).
REQ-018 mpu_start  output  1  one-cycle compute launch pulse.
REQ-019 mpu_done  input  1  MPU result-valid pulse.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, DRAIN, COMPUTE, FINISH.
- IDLE -> FETCH when start = 1.
- FETCH -> DRAIN after the 2*N*N-th address has been issued.
- DRAIN -> COMPUTE after one cycle.
- COMPUTE -> FINISH on mpu_done.
- COMPUTE -> IDLE on timeout.
- FINISH -> IDLE after one cycle.
REQ-021 a_base and b_base SHALL be captured in IDLE on the start cycle; changes while busy SHALL be ignored.
REQ-022 start while busy SHALL be ignored, with no queuing.
REQ-023 FETCH SHALL issue one address per cycle: a_base+k for k=0..N*N-1, then b_base+k for k=0..N*N-1. The sum is computed modulo 2^16, so addresses wrap from 0xFFFF to 0x0000.
REQ-024 The issue index SHALL be delayed one cycle to form ld_sel/ld_row/ld_col. Here ld_row = k/N, ld_col = k%N, and ld_en is high exactly the cycle after each issue.
REQ-025 Exactly 2*N*N ld_en pulses SHALL occur per operation, contiguous with no bubbles. The last pulse occurs in DRAIN.
REQ-026 mpu_start SHALL pulse in the first COMPUTE cycle only.
REQ-027 mpu_done SHALL be ignored outside COMPUTE. mpu_done coincident with the mpu_start cycle SHALL be ignored.
REQ-028 A COMPUTE cycle counter SHALL assert err and return to IDLE when it reaches TIMEOUT without mpu_done. done SHALL NOT pulse in that case.
REQ-029 done SHALL be high in the FINISH cycle only.
REQ-030 Latency for N=8: start at edge T gives first dram_addr at T+1, mpu_start at T+130, and done at mpu_done+1.
REQ-031 When ld_en = 0, dram_addr SHALL hold its last value, and ld_row/ld_col/ld_sel SHALL be don't-care.

Reset
REQ-032 On rst, the FSM SHALL go to IDLE, including mid-FETCH or mid-COMPUTE.
REQ-033 On rst, busy, done, err, ld_en, mpu_start and the counters SHALL be 0, and dram_addr SHALL be 0x0000.
REQ-034 An in-flight DRAM read SHALL produce no ld_en after reset.

Structure
REQ-035 Package mpu_pkg SHALL hold N, the state enum, and the address width (16) and data width (8).
REQ-036 Sub-module mpu_addr_gen SHALL hold the issue counter, base select, and the 1-cycle-delayed row/col/sel.
REQ-037 The FSM and timeout counter SHALL reside in mpu_load_ctrl.

Verification
REQ-038 Basic run, with DRAM[i]=i&0xFF, a_base=0x0000, b_base=0x0040, start pulse:
- Required: 128 ld_en pulses.
- A[r][c] = 8r+c; B[r][c] = 64+8r+c.
- mpu_start at T+130.
- done one cycle after mpu_done.
REQ-039 Wrap: a_base=0xFFF0 -> addresses 0xFFF0..0xFFFF then 0x0000..0x002F, with ld_data matching DRAM contents.
REQ-040 Busy start: start re-pulsed at T+50 with new bases -> ignored, with exactly 128 loads from the original bases.
REQ-041 Timeout: mpu_done never asserted -> err pulses TIMEOUT cycles after mpu_start, no done, busy low the next cycle.
REQ-042 Mid-operation reset: rst at FETCH index 20 -> next cycle IDLE, ld_en=0, busy=0. A fresh start then completes normally.
REQ-043 Stray done: mpu_done pulsed during FETCH -> ignored, no state change.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared constants and FSM state type for the MPU operand load controller.
package mpu_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned AddrW = 16;
    localparam int unsigned DataW = 8;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StCompute,
        StFinish
    } state_e;

endpackage

// File: rtl/mpu_addr_gen.sv
// DRAM read address sequencer for the A then B operands, plus the one-cycle-delayed
// element index that lines up with the returning read data.
module mpu_addr_gen
    import mpu_pkg::*;
#(
    parameter int unsigned N = mpu_pkg::N
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   issue_i,
    input  logic [AddrW-1:0]       a_base_i,
    input  logic [AddrW-1:0]       b_base_i,
    output logic [AddrW-1:0]       addr_o,
    output logic                   last_o,
    output logic                   ld_en_o,
    output logic                   ld_sel_o,
    output logic [$clog2(N)-1:0]   ld_row_o,
    output logic [$clog2(N)-1:0]   ld_col_o
);

    localparam int unsigned NN   = N * N;
    localparam int unsigned CntW = $clog2(2 * NN);
    localparam int unsigned IdxW = $clog2(N);

    localparam logic [CntW-1:0] LastCnt = CntW'(2 * NN - 1);
    localparam logic [CntW-1:0] NNCnt   = CntW'(NN);
    localparam logic [CntW-1:0] NCnt    = CntW'(N);

    logic [AddrW-1:0] a_base_q, b_base_q;
    logic [AddrW-1:0] addr_q;
    logic [CntW-1:0]  cnt_q;
    logic             ld_en_q, ld_sel_q;
    logic [IdxW-1:0]  ld_row_q, ld_col_q;

    logic [CntW-1:0]  nxt_cnt, nxt_off, cur_off;
    logic             nxt_sel, cur_sel;
    logic [AddrW-1:0] nxt_addr;
    logic [IdxW-1:0]  cur_row, cur_col;

    // cnt_q is the index being issued this cycle; addr_q already holds its address.
    always_comb begin
        nxt_cnt  = cnt_q + CntW'(1);
        nxt_sel  = (nxt_cnt >= NNCnt);
        nxt_off  = nxt_sel ? (nxt_cnt - NNCnt) : nxt_cnt;
        nxt_addr = (nxt_sel ? b_base_q : a_base_q) + AddrW'(nxt_off);

        cur_sel  = (cnt_q >= NNCnt);
        cur_off  = cur_sel ? (cnt_q - NNCnt) : cnt_q;
        cur_row  = IdxW'(cur_off / NCnt);
        cur_col  = IdxW'(cur_off % NCnt);
    end

    assign last_o = issue_i && (cnt_q == LastCnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_base_q <= '0;
            b_base_q <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            ld_en_q  <= 1'b0;
            ld_sel_q <= 1'b0;
            ld_row_q <= '0;
            ld_col_q <= '0;
        end else begin
            ld_en_q  <= issue_i;
            ld_sel_q <= cur_sel;
            ld_row_q <= cur_row;
            ld_col_q <= cur_col;
            if (start_i) begin
                a_base_q <= a_base_i;
                b_base_q <= b_base_i;
                cnt_q    <= '0;
                addr_q   <= a_base_i;
            end else if (issue_i && !last_o) begin
                cnt_q  <= nxt_cnt;
                addr_q <= nxt_addr;
            end
        end
    end

    assign addr_o   = addr_q;
    assign ld_en_o  = ld_en_q;
    assign ld_sel_o = ld_sel_q;
    assign ld_row_o = ld_row_q;
    assign ld_col_o = ld_col_q;

endmodule

// File: rtl/mpu_load_ctrl.sv
// Loads the A and B operands from DRAM into the MPU, launches the compute and
// waits for completion with a timeout.
module mpu_load_ctrl
    import mpu_pkg::*;
#(
    parameter int unsigned N       = mpu_pkg::N,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [AddrW-1:0]       a_base,
    input  logic [AddrW-1:0]       b_base,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [AddrW-1:0]       dram_addr,
    input  logic [DataW-1:0]       dram_dout,
    output logic                   ld_en,
    output logic                   ld_sel,
    output logic [$clog2(N)-1:0]   ld_row,
    output logic [$clog2(N)-1:0]   ld_col,
    output logic [DataW-1:0]       ld_data,
    output logic                   mpu_start,
    input  logic                   mpu_done
);

    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT);

    state_e          state_q, state_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            capture, issue, last, first_cmp, mpu_done_ok;

    mpu_addr_gen #(
        .N (N)
    ) u_addr_gen (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (capture),
        .issue_i  (issue),
        .a_base_i (a_base),
        .b_base_i (b_base),
        .addr_o   (dram_addr),
        .last_o   (last),
        .ld_en_o  (ld_en),
        .ld_sel_o (ld_sel),
        .ld_row_o (ld_row),
        .ld_col_o (ld_col)
    );

    // A done arriving alongside the launch pulse cannot belong to this launch.
    assign first_cmp   = (tmo_q == '0);
    assign mpu_done_ok = mpu_done && !first_cmp;

    always_comb begin
        state_d   = state_q;
        tmo_d     = '0;
        capture   = 1'b0;
        issue     = 1'b0;
        mpu_start = 1'b0;
        err       = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                issue = 1'b1;
                if (last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = StCompute;
            end
            StCompute: begin
                mpu_start = first_cmp;
                if (mpu_done_ok) begin
                    state_d = StFinish;
                end else if (tmo_q == TmoMax) begin
                    err     = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StFinish);
    assign ld_data = dram_dout;

endmodule

// File: tb/tb_mpu_load_ctrl.sv
// Directed bench for mpu_load_ctrl with a DRAM model holding DRAM[i] = i & 0xFF.
module tb_mpu_load_ctrl;

    localparam int N       = 8;
    localparam int NN      = N * N;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a_base = '0;
    logic [15:0] b_base = '0;
    logic        busy, done, err;
    logic [15:0] dram_addr;
    logic [7:0]  dram_dout;
    logic        ld_en, ld_sel;
    logic [2:0]  ld_row, ld_col;
    logic [7:0]  ld_data;
    logic        mpu_start;
    logic        mpu_done = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // One-cycle read latency, contents equal to the low address byte.
    always @(posedge clk) dram_dout <= dram_addr[7:0];

    mpu_load_ctrl #(
        .N       (N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_base    (a_base),
        .b_base    (b_base),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dram_addr (dram_addr),
        .dram_dout (dram_dout),
        .ld_en     (ld_en),
        .ld_sel    (ld_sel),
        .ld_row    (ld_row),
        .ld_col    (ld_col),
        .ld_data   (ld_data),
        .mpu_start (mpu_start),
        .mpu_done  (mpu_done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drives one operation (start in cycle 0) and records what the DUT did, in cycles
    // relative to the start cycle. mpu_done is driven d_delay cycles after mpu_start.
    task automatic run_op(input logic [15:0] ab, input logic [15:0] bb, input int d_delay,
                          input bit coinc, input int restart_at, input int stray_at,
                          output int n_ld, output int n_bad_ld, output int n_bad_addr,
                          output int t_ms, output int n_ms, output int t_done,
                          output int n_done, output int t_err, output int n_err,
                          output int t_idle);
        logic [15:0] exp_addr, base;
        logic [7:0]  exp_d;
        int          k, off;
        bit          exp_ld;
        n_ld = 0; n_bad_ld = 0; n_bad_addr = 0; n_ms = 0; n_done = 0; n_err = 0;
        t_ms = -1; t_done = -1; t_err = -1; t_idle = -1;
        @(negedge clk);
        start = 1'b1; a_base = ab; b_base = bb; mpu_done = 1'b0;
        for (int rel = 1; rel <= 1500; rel++) begin
            @(negedge clk);
            start  = 1'b0;
            a_base = 16'($urandom);
            b_base = 16'($urandom);
            if (rel <= 2 * NN) begin
                k = rel - 1;
                exp_addr = (k < NN) ? ab + 16'(k) : bb + 16'(k - NN);
                if (dram_addr !== exp_addr) n_bad_addr++;
            end
            exp_ld = (rel >= 2) && (rel <= 2 * NN + 1);
            if (ld_en !== exp_ld) n_bad_ld++;
            if (ld_en === 1'b1) begin
                k     = n_ld;
                off   = k % NN;
                base  = (k < NN) ? ab : bb;
                exp_d = 8'(base + 16'(off));
                if (ld_sel !== (k >= NN) || ld_row !== 3'(off / N) ||
                    ld_col !== 3'(off % N) || ld_data !== exp_d) n_bad_ld++;
                n_ld++;
            end
            if (mpu_start === 1'b1) begin n_ms++; if (t_ms < 0) t_ms = rel; end
            if (done === 1'b1) begin n_done++; if (t_done < 0) t_done = rel; end
            if (err === 1'b1) begin n_err++; if (t_err < 0) t_err = rel; end
            if (busy !== 1'b1) begin t_idle = rel; break; end
            mpu_done = (t_ms >= 0 && d_delay >= 0 && rel == t_ms + d_delay) ||
                       (coinc && rel == t_ms) || (rel == stray_at);
            if (rel == restart_at) begin
                start = 1'b1; a_base = ab ^ 16'h0101; b_base = bb ^ 16'h0202;
            end
        end
        mpu_done = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (ld_en !== 1'b0) begin errors++; $display("FAIL reset_ld_en: got %b want 0", ld_en); end
        checks++; if (mpu_start !== 1'b0) begin errors++; $display("FAIL reset_mpu_start: got %b want 0", mpu_start); end
        checks++; if (dram_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", dram_addr); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int n_ld, bl, ba, tms, nms, td, nd, te, ne, ti;
        run_op(16'h0000, 16'h0040, 5, 1'b0, 0, 0, n_ld, bl, ba, tms, nms, td, nd, te, ne, ti);
        checks++; if (n_ld != 128) begin errors++; $display("FAIL basic_ld_count: got %0d want 128", n_ld); end
        checks++; if (bl != 0) begin errors++; $display("FAIL basic_ld_content: got %0d bad want 0", bl); end
        checks++; if (ba != 0) begin errors++; $display("FAIL basic_addr_seq: got %0d bad want 0", ba); end
        checks++; if (tms != 130) begin errors++; $display("FAIL basic_mpu_start_time: got %0d want 130", tms); end
        checks++; if (nms != 1) begin errors++; $display("FAIL basic_mpu_start_count: got %0d want 1", nms); end
        checks++; if (td != 136) begin errors++; $display("FAIL basic_done_time: got %0d want 136", td); end
        checks++; if (nd != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", nd); end
        checks++; if (ne != 0) begin errors++; $display("FAIL basic_err_count: got %0d want 0", ne); end
        checks++; if (ti != 137) begin errors++; $display("FAIL basic_idle_time: got %0d want 137", ti); end
        checks++; if (dram_addr !== 16'h007F) begin errors++; $display("FAIL basic_addr_hold: got %h want 007f", dram_addr); end
    endtask

    task automatic test_wrap();
        int n_ld, bl, ba, tms, nms, td, nd, te, ne, ti;
        run_op(16'hFFF0, 16'h1234, 3, 1'b0, 0, 0, n_ld, bl, ba, tms, nms, td, nd, te, ne, ti);
        checks++; if (ba != 0) begin errors++; $display("FAIL wrap_addr_seq: got %0d bad want 0", ba); end
        checks++; if (bl != 0) begin errors++; $display("FAIL wrap_ld_content: got %0d bad want 0", bl); end
        checks++; if (n_ld != 128) begin errors++; $display("FAIL wrap_ld_count: got %0d want 128", n_ld); end
        checks++; if (td != 134) begin errors++; $display("FAIL wrap_done_time: got %0d want 134", td); end
    endtask

    task automatic test_busy_start();
        int n_ld, bl, ba, tms, nms, td, nd, te, ne, ti, nbusy;
        run_op(16'h0200, 16'h0300, 4, 1'b0, 50, 0, n_ld, bl, ba, tms, nms, td, nd, te, ne, ti);
        nbusy = 0;
        repeat (4) begin @(negedge clk); if (busy !== 1'b0) nbusy++; end
        checks++; if (n_ld != 128) begin errors++; $display("FAIL busy_start_ld_count: got %0d want 128", n_ld); end
        checks++; if (bl != 0) begin errors++; $display("FAIL busy_start_ld_content: got %0d bad want 0", bl); end
        checks++; if (ba != 0) begin errors++; $display("FAIL busy_start_addr_seq: got %0d bad want 0", ba); end
        checks++; if (nms != 1) begin errors++; $display("FAIL busy_start_mpu_start: got %0d want 1", nms); end
        checks++; if (nd != 1) begin errors++; $display("FAIL busy_start_done: got %0d want 1", nd); end
        checks++; if (nbusy != 0) begin errors++; $display("FAIL busy_start_no_queue: got %0d busy cycles want 0", nbusy); end
    endtask

    task automatic test_coincident_done();
        int n_ld, bl, ba, tms, nms, td, nd, te, ne, ti;
        run_op(16'h0000, 16'h0040, 7, 1'b1, 0, 0, n_ld, bl, ba, tms, nms, td, nd, te, ne, ti);
        checks++; if (td != 138) begin errors++; $display("FAIL coinc_done_time: got %0d want 138", td); end
        checks++; if (nd != 1) begin errors++; $display("FAIL coinc_done_count: got %0d want 1", nd); end
    endtask

    task automatic test_timeout();
        int n_ld, bl, ba, tms, nms, td, nd, te, ne, ti;
        run_op(16'h0400, 16'h0500, -1, 1'b0, 0, 0, n_ld, bl, ba, tms, nms, td, nd, te, ne, ti);
        checks++; if (te != 130 + TIMEOUT) begin errors++; $display("FAIL timeout_err_time: got %0d want %0d", te, 130 + TIMEOUT); end
        checks++; if (ne != 1) begin errors++; $display("FAIL timeout_err_count: got %0d want 1", ne); end
        checks++; if (nd != 0) begin errors++; $display("FAIL timeout_done_count: got %0d want 0", nd); end
        checks++; if (ti != 131 + TIMEOUT) begin errors++; $display("FAIL timeout_idle_time: got %0d want %0d", ti, 131 + TIMEOUT); end
    endtask

    task automatic test_stray_done();
        int n_ld, bl, ba, tms, nms, td, nd, te, ne, ti;
        @(negedge clk);
        mpu_done = 1'b1;
        @(negedge clk);
        mpu_done = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL stray_idle: got busy=%b done=%b want 0 0", busy, done); end
        run_op(16'h0600, 16'h0700, 2, 1'b0, 0, 30, n_ld, bl, ba, tms, nms, td, nd, te, ne, ti);
        checks++; if (n_ld != 128) begin errors++; $display("FAIL stray_ld_count: got %0d want 128", n_ld); end
        checks++; if (tms != 130) begin errors++; $display("FAIL stray_mpu_start_time: got %0d want 130", tms); end
        checks++; if (td != 133) begin errors++; $display("FAIL stray_done_time: got %0d want 133", td); end
        checks++; if (ba != 0) begin errors++; $display("FAIL stray_addr_seq: got %0d bad want 0", ba); end
    endtask

    task automatic test_mid_reset();
        int n_ld, bl, ba, tms, nms, td, nd, te, ne, ti;
        @(negedge clk);
        start = 1'b1; a_base = 16'h0100; b_base = 16'h0200;
        for (int rel = 1; rel <= 21; rel++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++; if (dram_addr !== 16'h0114) begin errors++; $display("FAIL midrst_addr20: got %h want 0114", dram_addr); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (ld_en !== 1'b0) begin errors++; $display("FAIL midrst_ld_en: got %b want 0", ld_en); end
        checks++; if (dram_addr !== 16'h0000) begin errors++; $display("FAIL midrst_addr: got %h want 0000", dram_addr); end
        @(negedge clk);
        checks++; if (ld_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_inflight: got ld_en=%b busy=%b want 0 0", ld_en, busy); end
        run_op(16'h0000, 16'h0040, 5, 1'b0, 0, 0, n_ld, bl, ba, tms, nms, td, nd, te, ne, ti);
        checks++; if (n_ld != 128 || bl != 0) begin errors++; $display("FAIL midrst_rerun_ld: got %0d loads %0d bad want 128 0", n_ld, bl); end
        checks++; if (td != 136) begin errors++; $display("FAIL midrst_rerun_done: got %0d want 136", td); end
    endtask

    task automatic test_back_to_back();
        int n_ld, bl, ba, tms, nms, td, nd, te, ne, ti;
        for (int i = 0; i < 2; i++) begin
            run_op(16'h0800 + 16'(i * 16'h0100), 16'h0880 + 16'(i * 16'h0100), 1 + i, 1'b0, 0, 0,
                   n_ld, bl, ba, tms, nms, td, nd, te, ne, ti);
            checks++; if (bl != 0 || ba != 0 || n_ld != 128) begin errors++; $display("FAIL b2b_loads[%0d]: got %0d loads %0d/%0d bad want 128 0/0", i, n_ld, bl, ba); end
            checks++; if (td != 132 + i) begin errors++; $display("FAIL b2b_done_time[%0d]: got %0d want %0d", i, td, 132 + i); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_busy_start();
        test_coincident_done();
        test_timeout();
        test_stray_done();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
